// File: rtl/bram_axi4_ctrl.sv
// bram_axi4_ctrl: AXI4 slave sequencing one single-port 64-bit BRAM.
// Ports: clock/reset, AXI4 AW/W/B/AR/R channels, and the BRAM port (addr/en/we/wdata/rdata).
module bram_axi4_ctrl #(
  parameter int ADDR_W = 13
) (
  input  logic              clock,
  input  logic              reset,
  output logic              bram_axi4_aw_ready,
  input  logic              bram_axi4_aw_valid,
  input  logic [3:0]        bram_axi4_aw_id,
  input  logic [30:0]       bram_axi4_aw_addr,
  input  logic [7:0]        bram_axi4_aw_len,
  input  logic [2:0]        bram_axi4_aw_size,
  input  logic [1:0]        bram_axi4_aw_burst,
  output logic              bram_axi4_w_ready,
  input  logic              bram_axi4_w_valid,
  input  logic [63:0]       bram_axi4_w_data,
  input  logic [7:0]        bram_axi4_w_strb,
  input  logic              bram_axi4_w_last,
  input  logic              bram_axi4_b_ready,
  output logic              bram_axi4_b_valid,
  output logic [3:0]        bram_axi4_b_id,
  output logic [1:0]        bram_axi4_b_resp,
  output logic              bram_axi4_ar_ready,
  input  logic              bram_axi4_ar_valid,
  input  logic [3:0]        bram_axi4_ar_id,
  input  logic [30:0]       bram_axi4_ar_addr,
  input  logic [7:0]        bram_axi4_ar_len,
  input  logic [2:0]        bram_axi4_ar_size,
  input  logic [1:0]        bram_axi4_ar_burst,
  input  logic              bram_axi4_r_ready,
  output logic              bram_axi4_r_valid,
  output logic [3:0]        bram_axi4_r_id,
  output logic [63:0]       bram_axi4_r_data,
  output logic [1:0]        bram_axi4_r_resp,
  output logic              bram_axi4_r_last,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_en,
  output logic [7:0]        bram_we,
  output logic [63:0]       bram_wdata,
  input  logic [63:0]       bram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_DATA,
    S_WR_RESP,
    S_RD_ISSUE,
    S_RD_CAPT,
    S_RD_RESP
  } state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [ADDR_W-1:0] IDX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic              r_last_rd;
  logic [3:0]        r_id;
  logic [ADDR_W-1:0] r_idx;
  logic [7:0]        r_len;
  logic [7:0]        r_cnt;
  logic              r_fixed;
  logic              r_bad_burst;
  logic              r_err;
  logic [63:0]       r_rdata;

  logic              w_idle;
  logic              w_grant_rd;
  logic              w_grant_wr;
  logic              w_beat_last;
  logic              w_w_hs;
  logic [ADDR_W-1:0] w_idx_next;
  logic              w_unused;

  assign w_idle = (r_state == S_IDLE);

  // On a tie, alternate: the side that did not win last time goes now.
  assign w_grant_rd = bram_axi4_ar_valid &
                      (~bram_axi4_aw_valid | ~r_last_rd);
  assign w_grant_wr = bram_axi4_aw_valid & ~w_grant_rd;

  assign w_beat_last = (r_cnt == r_len);
  assign w_w_hs      = (r_state == S_WR_DATA) & bram_axi4_w_valid;
  // WRAP and reserved bursts step like INCR; the index wraps naturally.
  assign w_idx_next  = r_fixed ? r_idx : r_idx + IDX_ONE;

  assign bram_axi4_aw_ready = w_idle & w_grant_wr;
  assign bram_axi4_ar_ready = w_idle & w_grant_rd;
  assign bram_axi4_w_ready  = (r_state == S_WR_DATA);

  assign bram_axi4_b_valid = (r_state == S_WR_RESP);
  assign bram_axi4_b_id    = r_id;
  assign bram_axi4_b_resp  =
    ((r_state == S_WR_RESP) && (r_err || r_bad_burst)) ?
    RESP_SLVERR : RESP_OKAY;

  assign bram_axi4_r_valid = (r_state == S_RD_RESP);
  assign bram_axi4_r_id    = r_id;
  assign bram_axi4_r_data  = r_rdata;
  assign bram_axi4_r_resp  =
    ((r_state == S_RD_RESP) && r_bad_burst) ? RESP_SLVERR : RESP_OKAY;
  assign bram_axi4_r_last  = (r_state == S_RD_RESP) && w_beat_last;

  // Reset kills the BRAM strobe in the same cycle so an aborted burst
  // never touches memory again.
  assign bram_en    = ~reset & (w_w_hs | (r_state == S_RD_ISSUE));
  assign bram_we    = (~reset & w_w_hs) ? bram_axi4_w_strb : 8'h00;
  assign bram_wdata = bram_axi4_w_data;
  assign bram_addr  = r_idx;

  assign w_unused = ^{bram_axi4_aw_size, bram_axi4_ar_size,
                      bram_axi4_aw_addr[30:ADDR_W+3],
                      bram_axi4_aw_addr[2:0],
                      bram_axi4_ar_addr[30:ADDR_W+3],
                      bram_axi4_ar_addr[2:0],
                      bram_axi4_ar_burst[0], bram_axi4_aw_burst[0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_last_rd   <= 1'b0;
      r_id        <= '0;
      r_idx       <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_fixed     <= 1'b0;
      r_bad_burst <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_rd) begin
            r_id        <= bram_axi4_ar_id;
            r_idx       <= bram_axi4_ar_addr[ADDR_W+2:3];
            r_len       <= bram_axi4_ar_len;
            r_fixed     <= (bram_axi4_ar_burst == BURST_FIXED);
            r_bad_burst <= bram_axi4_ar_burst[1];
            r_cnt       <= '0;
            r_last_rd   <= 1'b1;
            r_state     <= S_RD_ISSUE;
          end else if (w_grant_wr) begin
            r_id        <= bram_axi4_aw_id;
            r_idx       <= bram_axi4_aw_addr[ADDR_W+2:3];
            r_len       <= bram_axi4_aw_len;
            r_fixed     <= (bram_axi4_aw_burst == BURST_FIXED);
            r_bad_burst <= bram_axi4_aw_burst[1];
            r_cnt       <= '0;
            r_last_rd   <= 1'b0;
            r_state     <= S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (bram_axi4_w_valid) begin
            // Burst length comes from len; w_last is only checked.
            if (bram_axi4_w_last != w_beat_last) r_err <= 1'b1;
            r_idx <= w_idx_next;
            r_cnt <= r_cnt + 8'd1;
            if (w_beat_last) r_state <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (bram_axi4_b_ready) begin
            r_err   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_RD_ISSUE: r_state <= S_RD_CAPT;
        S_RD_CAPT: begin
          r_rdata <= bram_rdata;
          r_state <= S_RD_RESP;
        end
        S_RD_RESP: begin
          if (bram_axi4_r_ready) begin
            if (w_beat_last) begin
              r_state <= S_IDLE;
            end else begin
              r_idx   <= w_idx_next;
              r_cnt   <= r_cnt + 8'd1;
              r_state <= S_RD_ISSUE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/bram_axi4_ctrl.md
# bram_axi4_ctrl

AXI4 slave controller that sequences the single-port boot/scratch BRAM behind the crossbar. It accepts full AXI4 read and write bursts on the 64-bit crossbar port and arbitrates reads against writes for the one BRAM port. It drives `bram_storage` directly with a word-indexed address, per-byte write enables and a one-cycle read latency.

## Interface
- `ADDR_W`, default 13: BRAM word-index width (2^13 × 64 bit = 64 KiB).
- `clock`, input, 1: single clock for AXI and BRAM.
- `reset`, input, 1: synchronous, active-high.
- `bram_axi4_aw_ready`, output, 1; `bram_axi4_aw_valid`, input, 1; `bram_axi4_aw_id`, input, 4; `bram_axi4_aw_addr`, input, 31; `bram_axi4_aw_len`, input, 8; `bram_axi4_aw_size`, input, 3; `bram_axi4_aw_burst`, input, 2: write address channel.
- `bram_axi4_w_ready`, output, 1; `bram_axi4_w_valid`, input, 1; `bram_axi4_w_data`, input, 64; `bram_axi4_w_strb`, input, 8; `bram_axi4_w_last`, input, 1: write data channel.
- `bram_axi4_b_ready`, input, 1; `bram_axi4_b_valid`, output, 1; `bram_axi4_b_id`, output, 4; `bram_axi4_b_resp`, output, 2: write response channel.
- `bram_axi4_ar_ready`, output, 1; `bram_axi4_ar_valid`, input, 1; `bram_axi4_ar_id`, input, 4; `bram_axi4_ar_addr`, input, 31; `bram_axi4_ar_len`, input, 8; `bram_axi4_ar_size`, input, 3; `bram_axi4_ar_burst`, input, 2: read address channel.
- `bram_axi4_r_ready`, input, 1; `bram_axi4_r_valid`, output, 1; `bram_axi4_r_id`, output, 4; `bram_axi4_r_data`, output, 64; `bram_axi4_r_resp`, output, 2; `bram_axi4_r_last`, output, 1: read data channel.
- `bram_addr`, output, ADDR_W: word index.
- `bram_en`, output, 1: BRAM enable.
- `bram_we`, output, 8: per-byte write enable.
- `bram_wdata`, output, 64: write data.
- `bram_rdata`, input, 64: read data, valid in the cycle after `bram_en` is asserted with `bram_we`=0.

## Operation
- **FSM states:** IDLE, WR_DATA, WR_RESP, RD_ISSUE, RD_CAPT, RD_RESP.
- **IDLE, arbitration:**
  - If only one of aw_valid/ar_valid is high, grant it.
  - If both are high, grant the side opposite to `last_grant`. `last_grant` resets to "write", so reads win the first tie.
  - Granted ready is high for exactly one cycle (combinational in IDLE with the grant). On that cycle latch id, addr[ADDR_W+2:3] as the word index, len and burst.
  - Clear the beat counter, set `last_grant`, and go to WR_DATA or RD_ISSUE.
- **Address rules:**
  - addr[2:0] and addr above bit ADDR_W+2 are ignored; the region aliases.
  - size is ignored: every beat is one 64-bit word and strobes select bytes.
  - INCR: the index advances by 1 per beat and wraps from 2^ADDR_W−1 to 0.
  - FIXED: the index stays constant.
  - WRAP (2'b10) and reserved (2'b11) are executed as INCR, and the response is SLVERR (2'b10) on every beat or on B.
- **WR_DATA:**
  - w_ready=1.
  - On each w handshake, the same cycle drives bram_en=1, bram_we=w_strb, bram_wdata=w_data, bram_addr=current index; then the index and counter advance.
  - The burst ends on beat len+1, determined by the counter.
  - If w_last≠(counter==len) on any beat, set the sticky error flag.
  - After the final beat go to WR_RESP.
- **WR_RESP:**
  - b_valid=1, b_id=latched id.
  - b_resp=SLVERR if the error flag or an illegal burst is set, else OKAY.
  - On b_ready go to IDLE and clear the error flag.
- **RD_ISSUE:** bram_en=1, bram_we=0, bram_addr=index; go to RD_CAPT.
- **RD_CAPT:** register bram_rdata into the r_data holding register; go to RD_RESP.
- **RD_RESP:**
  - r_valid=1, r_id=latched id, r_last=(counter==len), r_resp per the burst rule.
  - Hold all r outputs stable until r_ready.
  - On handshake: if last, go to IDLE; else advance the index and counter and go to RD_ISSUE.
- bram_en=0 and bram_we=0 in every state or cycle not listed above.
- No outstanding-transaction overlap: a new AW/AR is accepted only in IDLE.

## Timing
- **Reset:** state=IDLE, last_grant=write. All ready/valid outputs are 0, bram_en=0, bram_we=0, r_data/b_resp/r_resp/ids=0.
- **Reset asserted mid-burst:** abort immediately, with no further BRAM enables and no B/R completion. Beats already written stay in BRAM.
- **Write:**
  - AW accept takes 1 cycle; each beat takes 1 cycle with w_valid held high.
  - b_valid is asserted the cycle after the last W handshake.
  - Minimum single-beat write: AW at cycle 0, W at 1, B at 2.
- **Read:**
  - AR accept at cycle 0, bram_en at 1, capture at 2, r_valid at 3.
  - Each subsequent beat's r_valid comes 3 cycles after the previous beat's handshake (RD_ISSUE follows in the next cycle).
- **Back-to-back transactions:** return to IDLE costs 1 cycle, so the next transaction is accepted no earlier than the cycle after B/last-R completion.

## Test plan
- **Single write then read:** AW addr=0x10, len=0, W data=0x1122334455667788, strb=0xFF → bram_we=0xFF at word 2, b_resp=OKAY. AR addr=0x10 → r_data=0x1122334455667788, r_last=1, r_valid at cycle 3 after AR.
- **4-beat INCR write with strobes:** base 0x40, strb 0x0F/0xF0/0xFF/0x00 → words 8–11 written bytewise. Then a 4-beat read under random r_ready stalls → data held stable while stalled, r_last only on beat 4.
- **Simultaneous AW and AR:** assert both together for three consecutive transactions → grant order read, write, read.
- **FIXED burst and top-of-memory wrap:** FIXED write len=3 at 0x8 → all beats hit word 1, last data wins. INCR write at index 8191, len=1 → second beat at index 0.
- **Error cases:** WRAP-burst read len=1 → r_resp=2'b10 on both beats. A write with w_last early on beat 1 of a 3-beat burst → burst still completes 3 beats, b_resp=2'b10.
- **Reset mid-operation:** reset at beat 2 of an 8-beat read, held 1 cycle → next cycle r_valid=0, bram_en=0, state IDLE. A new AR is accepted normally afterwards.
